// File: rtl/spi_slave_ram_burst.sv
// SPI slave with an internal single-port RAM: 2-bit command frames set addresses, write or read.
// Optional address post-increment for bursts is enabled by defining SPI_RAM_AUTO_INC_EN.
module spi_slave_ram_burst #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic abort
);

    localparam int unsigned PW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(PW + 1);

    typedef enum logic [2:0] {StIdle, StCmd, StRxPayload, StRdWait, StRdData} state_e;

    state_e            r_state;
    logic [1:0]        r_cmd;
    logic              r_cmd_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW-1:0]     r_rx;
    logic [DATA_W-1:0] r_tx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_abort;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [PW-1:0]     w_rx_next;
    logic              w_last_rx;
    logic              w_last_rd;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rd_word;
    state_e            w_end_state;

    assign w_rx_next     = (r_rx << 1) | PW'(MOSI);
    assign w_last_rx     = (r_cnt == CNT_W'(PW - 1));
    assign w_last_rd     = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_wr_in_range = (32'(r_wr_addr) < MEM_DEPTH);
    assign w_rd_in_range = (32'(r_rd_addr) < MEM_DEPTH);
    assign w_rd_word     = w_rd_in_range ? r_mem[r_rd_addr] : '0;
    assign w_end_state   = SS_n ? StIdle : StCmd;
    // Reset must win over the final-bit write.
    assign w_mem_we      = !rst && (r_state == StRxPayload) && w_last_rx &&
                           (r_cmd == 2'b01) && w_wr_in_range;

`ifdef SPI_RAM_AUTO_INC_EN
    // Wraps at MEM_DEPTH-1; out-of-range addresses wrap naturally at all-ones.
    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_W'(1);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= w_rx_next[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cmd     <= '0;
            r_cmd_cnt <= 1'b0;
            r_cnt     <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!SS_n) begin
                        r_cmd[1]  <= MOSI;
                        r_cmd_cnt <= 1'b1;
                        r_state   <= StCmd;
                    end
                end
                StCmd: begin
                    if (SS_n) begin
                        r_state <= StIdle;
                        r_abort <= 1'b1;
                    end else if (!r_cmd_cnt) begin
                        r_cmd[1]  <= MOSI;
                        r_cmd_cnt <= 1'b1;
                    end else begin
                        r_cmd[0] <= MOSI;
                        r_cnt    <= '0;
                        r_state  <= (r_cmd[1] && MOSI) ? StRdWait : StRxPayload;
                    end
                end
                StRxPayload: begin
                    // The final bit completes the frame even if SS_n rises with it.
                    if (w_last_rx) begin
                        case (r_cmd)
                            2'b00:   r_wr_addr <= w_rx_next[ADDR_W-1:0];
                            2'b10:   r_rd_addr <= w_rx_next[ADDR_W-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
                            2'b01:   r_wr_addr <= f_inc(r_wr_addr);
`endif
                            default: ;
                        endcase
                        r_rx      <= w_rx_next;
                        r_cmd_cnt <= 1'b0;
                        r_state   <= w_end_state;
                    end else if (SS_n) begin
                        r_state <= StIdle;
                        r_abort <= 1'b1;
                    end else begin
                        r_rx  <= w_rx_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StRdWait: begin
                    if (SS_n) begin
                        r_state <= StIdle;
                        r_abort <= 1'b1;
                    end else begin
                        r_tx    <= w_rd_word;
                        r_cnt   <= '0;
                        r_state <= StRdData;
                    end
                end
                StRdData: begin
                    if (w_last_rd) begin
`ifdef SPI_RAM_AUTO_INC_EN
                        r_rd_addr <= f_inc(r_rd_addr);
`endif
                        r_cmd_cnt <= 1'b0;
                        r_state   <= w_end_state;
                    end else if (SS_n) begin
                        r_state <= StIdle;
                        r_abort <= 1'b1;
                    end else begin
                        r_tx  <= r_tx << 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign MISO  = (r_state == StRdData) ? r_tx[DATA_W-1] : 1'b0;
    assign busy  = (r_state != StIdle);
    assign abort = r_abort;

endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// Self-checking bench for spi_slave_ram_burst (MEM_DEPTH=200) against a frame-level model.
// Model follows SPI_RAM_AUTO_INC_EN when defined.
module tb_spi_slave_ram_burst;

    localparam int DEPTH = 200;
`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic abort;

    spi_slave_ram_burst #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO),
        .busy (busy),
        .abort(abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_mem   [256];
    bit         m_valid [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;

    function automatic logic [7:0] nxt(input logic [7:0] a);
        if (!AUTO) return a;
        return (int'(a) == DEPTH - 1) ? 8'd0 : a + 8'd1;
    endfunction

    function automatic bit known(input logic [7:0] a);
        return (int'(a) >= DEPTH) || m_valid[a];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, let the posedge sample, return just after it.
    task automatic cyc(input logic ss, input logic b);
        @(negedge clk);
        SS_n = ss;
        MOSI = b;
        @(posedge clk);
        #1;
    endtask

    // Command 00/01/10 frame; 'last' raises SS_n with the final payload bit.
    task automatic wframe(input logic [1:0] cmd, input logic [7:0] pl, input bit last);
        cyc(1'b0, cmd[1]);
        cyc(1'b0, cmd[0]);
        for (int i = 7; i >= 0; i--) cyc(last && i == 0, pl[i]);
        case (cmd)
            2'b00: m_wr = pl;
            2'b10: m_rd = pl;
            default: begin
                if (int'(m_wr) < DEPTH) begin
                    m_mem[m_wr]   = pl;
                    m_valid[m_wr] = 1'b1;
                end
                m_wr = nxt(m_wr);
            end
        endcase
    endtask

    task automatic rframe(input bit last, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        exp = (int'(m_rd) < DEPTH) ? m_mem[m_rd] : 8'h00;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk({tag, "_wait_miso"}, 8'(MISO), 8'd0);
        cyc(1'b0, 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            got[7-i] = MISO;
            cyc(last && i == 7, 1'($urandom));
        end
        chk(tag, got, exp);
        m_rd = nxt(m_rd);
    endtask

    initial begin
        logic [7:0] a;
        int         n;
        int         op;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
        m_wr = 8'h00;
        m_rd = 8'h00;
        rst  = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) cyc(1'b1, 1'b0);
        chk("reset_outputs", {5'd0, MISO, busy, abort}, 8'd0);
        rst = 1'b0;

        // Idle with SS_n high
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'($urandom));
            chk("idle_quiet", {5'd0, MISO, busy, abort}, 8'd0);
        end

        wframe(2'b00, 8'h00, 1'b0);
        wframe(2'b01, 8'h5A, 1'b1);
        cyc(1'b1, 1'b0);

        // Four frames in one SS_n window
        wframe(2'b00, 8'h12, 1'b0);
        chk("busy_b2b_0", 8'(busy), 8'd1);
        wframe(2'b01, 8'hA5, 1'b0);
        chk("busy_b2b_1", 8'(busy), 8'd1);
        wframe(2'b10, 8'h12, 1'b0);
        chk("busy_b2b_2", 8'(busy), 8'd1);
        rframe(1'b1, "b2b_read");
        chk("busy_after_window", 8'(busy), 8'd0);
        cyc(1'b1, 1'b0);

        // Burst across the MEM_DEPTH wrap
        wframe(2'b00, 8'(DEPTH - 2), 1'b0);
        wframe(2'b01, 8'h11, 1'b0);
        wframe(2'b01, 8'h22, 1'b0);
        wframe(2'b01, 8'h33, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'(DEPTH - 2), 1'b0);
        rframe(1'b0, "burst_rd0");
        rframe(1'b0, "burst_rd1");
        rframe(1'b1, "burst_rd2");
        cyc(1'b1, 1'b0);

        // Abort mid WR_DATA payload
        wframe(2'b00, 8'h40, 1'b0);
        wframe(2'b01, 8'hC3, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b00, 8'h40, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        chk("abort_before", 8'(abort), 8'd0);
        cyc(1'b1, 1'b0);
        chk("abort_pulse", {5'd0, MISO, busy, abort}, 8'd1);
        cyc(1'b1, 1'b0);
        chk("abort_one_cycle", 8'(abort), 8'd0);
        wframe(2'b10, 8'h40, 1'b0);
        rframe(1'b1, "abort_mem_kept");
        cyc(1'b1, 1'b0);
        wframe(2'b01, 8'h3C, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'h40, 1'b0);
        rframe(1'b1, "abort_wr_addr_kept");
        cyc(1'b1, 1'b0);

        // Abort mid RD_DATA: no rd_addr change
        wframe(2'b10, 8'h40, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rd_abort_pulse", {5'd0, MISO, busy, abort}, 8'd1);
        cyc(1'b1, 1'b0);
        rframe(1'b1, "rd_abort_addr_kept");
        cyc(1'b1, 1'b0);

        // Out-of-range write dropped, read returns zero
        wframe(2'b00, 8'hC8, 1'b0);
        wframe(2'b01, 8'hC8, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'hC8, 1'b0);
        rframe(1'b1, "oor_read_zero");
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'h00, 1'b0);
        rframe(1'b1, "oor_mem0_kept");
        cyc(1'b1, 1'b0);

        // Reset on the final WR_DATA bit
        wframe(2'b00, 8'h30, 1'b0);
        wframe(2'b01, 8'h99, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b00, 8'h30, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        for (int i = 7; i >= 1; i--) cyc(1'b0, 1'b0);
        @(negedge clk);
        rst  = 1'b1;
        MOSI = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 8'(busy), 8'd0);
        m_wr = 8'h00;
        m_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        rframe(1'b1, "rst_rd_addr_zero");
        cyc(1'b1, 1'b0);
        wframe(2'b01, 8'hE1, 1'b1);
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'h30, 1'b0);
        rframe(1'b1, "rst_no_write");
        cyc(1'b1, 1'b0);
        wframe(2'b10, 8'h00, 1'b0);
        rframe(1'b1, "rst_wr_addr_zero");
        cyc(1'b1, 1'b0);

        // Randomised windows
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                n = int'($urandom_range(1, 4));
                wframe(2'b00, 8'($urandom), 1'b0);
                for (int j = 0; j < n; j++) wframe(2'b01, 8'($urandom), j == n - 1);
            end else if (op == 1) begin
                a = 8'h00;
                for (int t = 0; t < 50; t++) begin
                    a = 8'($urandom_range(0, DEPTH - 1));
                    if (m_valid[a]) break;
                    a = 8'h00;
                end
                n = 1;
                for (int j = 1; j < 3; j++) begin
                    if (!known(8'(int'(a) + j >= DEPTH && AUTO ? int'(a) + j - DEPTH
                                                           : (AUTO ? int'(a) + j : int'(a)))))
                        break;
                    n++;
                end
                wframe(2'b10, a, 1'b0);
                for (int j = 0; j < n; j++) rframe(j == n - 1, "rand_read");
            end else begin
                wframe(2'b10, 8'($urandom_range(DEPTH, 255)), 1'b0);
                rframe(1'b1, "rand_oor_read");
            end
            cyc(1'b1, 1'b0);
            chk("rand_idle", {5'd0, MISO, busy, abort}, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
